// File: rtl/mean3x3_stream.sv
// mean3x3_stream: 3x3 trailing-window box mean over a raster multi-channel pixel stream, 3-cycle latency.
// Optional build macro MEAN3X3_ROUND_EN selects round-half-up instead of truncation.

module mean3x3_lane #(
    parameter int CH_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [9*CH_W-1:0] win,
    output logic [CH_W-1:0]   mean
);
    localparam int SW = CH_W + 4;
    // With M = ceil(2^S/9) the error term x*(9M-2^S) stays below 2^S for every sum, so the quotient is exact.
    localparam int S  = SW + 3;
    localparam int M  = ((1 << S) + 8) / 9;
    localparam int PW = SW + S;

    logic [SW-1:0] sum_c;
    logic [SW-1:0] sum_q;
    logic [SW-1:0] sum_adj;
    logic [PW-1:0] prod;
    logic          unused_prod;

    always_comb begin
        sum_c = '0;
        for (int i = 0; i < 9; i++)
            sum_c = sum_c + SW'(win[i*CH_W +: CH_W]);
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)  sum_q <= '0;
        else if (en) sum_q <= sum_c;

`ifdef MEAN3X3_ROUND_EN
    assign sum_adj = sum_q + SW'(4);
`else
    assign sum_adj = sum_q;
`endif

    assign prod        = PW'(sum_adj) * PW'(M);
    assign mean        = prod[S +: CH_W];
    assign unused_prod = ^{prod[S-1:0], prod[PW-1:S+CH_W]};
endmodule

module mean3x3_stream #(
    parameter int CH_W  = 8,
    parameter int CH_N  = 3,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic                 in_sof,
    input  logic [CH_N*CH_W-1:0] in_data,
    output logic                 out_valid,
    output logic                 out_sof,
    output logic [CH_N*CH_W-1:0] out_data
);
    localparam int DW     = CH_N * CH_W;
    localparam int CW     = $clog2(IMG_W);
    localparam int RW     = $clog2(IMG_H);
    localparam int STAGES = 3;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0]           col, pos_col;
    logic [RW-1:0]           row, pos_row;
    logic [DW-1:0]           lb1 [IMG_W];
    logic [DW-1:0]           lb2 [IMG_W];
    logic [DW-1:0]           lb1_rd, lb2_rd;
    logic [2:0][2:0][DW-1:0] win;
    logic [STAGES-1:0]       vld_pipe;
    logic                    byp1, sof1, byp2, sof2;
    logic [DW-1:0]           raw2;
    logic [DW-1:0]           mean_px;

    // sof forces the current pixel to (0,0) whatever the counters say
    assign pos_col = in_sof ? '0 : col;
    assign pos_row = in_sof ? '0 : row;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (in_valid) begin
            if (pos_col == COL_LAST) begin
                col <= '0;
                row <= (pos_row == ROW_LAST) ? '0 : pos_row + 1'b1;
            end else begin
                col <= pos_col + 1'b1;
                row <= pos_row;
            end
        end

    assign lb1_rd = lb1[pos_col];
    assign lb2_rd = lb2[pos_col];

    // Line buffers carry no reset; rows 0-1 bypass so stale entries never reach the output.
    always_ff @(posedge clk)
        if (in_valid) begin
            lb1[pos_col] <= in_data;
            lb2[pos_col] <= lb1_rd;
        end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            win  <= '0;
            byp1 <= 1'b0;
            sof1 <= 1'b0;
        end else if (in_valid) begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[0][2] <= lb2_rd;
            win[1][2] <= lb1_rd;
            win[2][2] <= in_data;
            byp1      <= (pos_row < RW'(2)) || (pos_col < CW'(2));
            sof1      <= (pos_row == '0) && (pos_col == '0);
        end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) vld_pipe <= '0;
        else        vld_pipe <= {vld_pipe[STAGES-2:0], in_valid};

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            byp2 <= 1'b0;
            sof2 <= 1'b0;
            raw2 <= '0;
        end else if (vld_pipe[0]) begin
            byp2 <= byp1;
            sof2 <= sof1;
            raw2 <= win[2][2];
        end

    for (genvar k = 0; k < CH_N; k++) begin : g_lane
        logic [9*CH_W-1:0] lane_win;
        for (genvar i = 0; i < 9; i++) begin : g_tap
            assign lane_win[i*CH_W +: CH_W] = win[i/3][i%3][k*CH_W +: CH_W];
        end
        mean3x3_lane #(.CH_W(CH_W)) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (vld_pipe[0]),
            .win   (lane_win),
            .mean  (mean_px[k*CH_W +: CH_W])
        );
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            out_sof  <= 1'b0;
            out_data <= '0;
        end else begin
            out_sof <= vld_pipe[1] & sof2;
            if (vld_pipe[1]) out_data <= byp2 ? raw2 : mean_px;
        end

    assign out_valid = vld_pipe[STAGES-1];
endmodule
